dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Controller that shares the single-port data memory between two requesters: the pipeline MEM stage and a memory loader/debug port. It arbitrates between the two, sequences each access over a fixed memory latency, and stalls the pipeline until its access completes. It sits between the MEM stage and the data memory array, and replaces direct MEM-stage drive of the array.

Parameters:
ADDR_W, 5, word-address width (32-word data memory)
DATA_W, 32, data width
MEM_LAT, 2, memory access latency in cycles (>=1), counted from the m_en cycle
STARVE_MAX, 4, maximum consecutive pipeline grants while l_req is waiting

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
p_req  in  1  pipeline access request (memRead|memWrite); held stable while p_stall=1
p_we  in  1  pipeline write enable
p_addr  in  ADDR_W  pipeline word address (ALU result)
p_wdata  in  DATA_W  pipeline store data (Rt data)
p_rdata  out  DATA_W  pipeline load data, valid when p_req=1 and p_stall=0
p_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
l_req  in  1  loader request, held until l_ack
l_we  in  1  loader write enable
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_rdata  out  DATA_W  loader read data, valid with l_ack
l_ack  out  1  one-cycle completion pulse
m_en  out  1  memory access strobe, one cycle per access
m_we  out  1  memory write enable, qualified by m_en
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid MEM_LAT-1 cycles after the m_en cycle

Behaviour:
- Reset (rst=0, immediate): state IDLE, owner=PIPE, starve count 0; p_rdata, l_rdata, m_addr and m_wdata are 0; l_ack, m_en and m_we are 0. An in-flight access is abandoned; a write already strobed is not rolled back.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: the block stays in IDLE.
  - Any request: the block picks a winner, latches the winner's we, addr and wdata into m_we, m_addr and m_wdata, sets m_en<=1 and cnt<=MEM_LAT-1, and goes to BUSY.
- Arbitration: the pipeline wins by default. The loader wins when p_req=0, or when l_req=1 and the starve count is >= STARVE_MAX.
- Starve count:
  - Increments on each pipeline grant while l_req=1, saturating at STARVE_MAX.
  - Clears on a loader grant, or on a pipeline grant with l_req=0.
- BUSY:
  - m_en is 1 only in the first BUSY cycle; m_addr, m_we and m_wdata are held for the whole access.
  - While cnt>0, cnt decrements each cycle.
  - When cnt==0, the block captures m_rdata into p_rdata or l_rdata (per owner) and goes to RESP. Writes also take the full latency; their captured rdata is don't-care, and the stored value remains unchanged.
- RESP:
  - Owner PIPE: p_stall=0 this cycle, so the pipeline advances.
  - Owner LDR: l_ack=1 this cycle.
  - The next state is always IDLE; new requests are not sampled in RESP.
- p_stall = p_req AND NOT (state==RESP AND owner==PIPE). It is combinational, so a request stalls in its first cycle.
- Pipeline access timing: request at cycle 0, m_en at cycle 1, release at cycle MEM_LAT+1. Stall lasts MEM_LAT+1 cycles.
- Pipeline request arriving while the loader owns the memory: the pipeline stalls through the loader's RESP, then is arbitrated in the following IDLE.
- A loader deasserting l_req mid-access is not supported; the access completes and l_ack still pulses.
- Addresses are ADDR_W bits, so there are no out-of-range cases; addresses wrap naturally.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding: IDLE=2'b00, BUSY=2'b01, RESP=2'b10.
  - Owner constants: OWN_PIPE=1'b0, OWN_LDR=1'b1.
  - Latency counter width: $clog2(MEM_LAT)+1.
- One sub-module, dmem_arb_fair:
  - Contains the starve counter and the grant decision.
  - Inputs: p_req, l_req, and the grant event from IDLE.
  - Output: winner.
- The top level holds the FSM, latency counter and datapath registers.

Test Plan:
1. Reset mid-BUSY (MEM_LAT=2, pipeline read in flight), rst=0 asynchronously -> m_en=0, l_ack=0, p_rdata=0 before the next edge; after release, p_stall=p_req and the state returns to IDLE.
2. Pipeline read, addr 5, model returns 0x00000005 -> p_stall=1 in cycles 0-2 and 0 in cycle 3; p_rdata=0x00000005 in cycle 3; m_en=1 only in cycle 1 with m_addr=5, m_we=0.
3. Loader write, addr 21, data 0xDEADBEEF, then pipeline read of addr 21 -> l_ack pulses once in cycle 3; the following read returns p_rdata=0xDEADBEEF.
4. p_req and l_req asserted together in IDLE, pipeline drops after one access -> pipeline is granted first; the loader is granted in the next IDLE and l_ack follows 3 cycles later.
5. Back-to-back pipeline requests with l_req held (STARVE_MAX=4) -> the 5th grant goes to the loader; the starve count clears; the pipeline stays stalled through the loader's RESP.
6. MEM_LAT=1, pipeline read of addr 0 -> p_stall=1 in cycles 0-1, released in cycle 2, p_rdata=0x00000000.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : access sequencer states
//   OwnPipe/OwnLdr : owner encoding for the current access
//   lat_cnt_w() : width of the latency down-counter for a given MEM_LAT
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } arb_state_e;

    localparam logic OwnPipe = 1'b0;
    localparam logic OwnLdr  = 1'b1;

    function automatic int unsigned lat_cnt_w(input int unsigned mem_lat);
        return $clog2(mem_lat) + 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: pipeline MEM-stage port (p_*),
// loader/debug port (l_*) and the single-port memory array side (m_*).
//   slave  : arbiter view (requests and m_rdata in; responses and strobes out)
//   master : environment view (requesters plus memory array)
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_stall;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] l_rdata;
    logic              l_ack;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  m_rdata,
        output p_rdata, p_stall,
        output l_rdata, l_ack,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output m_rdata,
        input  p_rdata, p_stall,
        input  l_rdata, l_ack,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/dmem_arb_fair.sv
// Grant decision with loader anti-starvation.
//   clk, rst : clock, asynchronous active-low reset
//   p_req    : pipeline request
//   l_req    : loader request
//   grant    : an access is being granted this cycle (IDLE with a request)
//   winner   : OwnPipe / OwnLdr, meaningful when grant=1
module dmem_arb_fair
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p_req,
    input  logic l_req,
    input  logic grant,
    output logic winner
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    // Pipeline has priority unless it is idle or the loader has waited long enough.
    assign winner = (!p_req || (l_req && (starve_q >= StarveMax))) ? OwnLdr : OwnPipe;

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (winner == OwnLdr || !l_req) begin
                starve_d = '0;
            end else if (starve_q < StarveMax) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and the
// loader/debug port. Each access: IDLE (grant) -> BUSY for MEM_LAT cycles
// (m_en in the first) -> RESP (pipeline released or loader acked) -> IDLE.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : p_* pipeline port, l_* loader port, m_* memory array port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned CntW = lat_cnt_w(MEM_LAT);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
    logic              grant;
    logic              winner;

    dmem_arb_fair #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fair (
        .clk    (clk),
        .rst    (rst),
        .p_req  (bus.p_req),
        .l_req  (bus.l_req),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        m_en_d    = 1'b0;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        p_rdata_d = p_rdata_q;
        l_rdata_d = l_rdata_q;
        grant     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.p_req || bus.l_req) begin
                    grant   = 1'b1;
                    owner_d = winner;
                    if (winner == OwnLdr) begin
                        m_we_d    = bus.l_we;
                        m_addr_d  = bus.l_addr;
                        m_wdata_d = bus.l_wdata;
                    end else begin
                        m_we_d    = bus.p_we;
                        m_addr_d  = bus.p_addr;
                        m_wdata_d = bus.p_wdata;
                    end
                    m_en_d  = 1'b1;
                    cnt_d   = CntW'(MEM_LAT - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Writes capture too; the value is simply ignored by the requester.
                    if (owner_q == OwnLdr) begin
                        l_rdata_d = bus.m_rdata;
                    end else begin
                        p_rdata_d = bus.m_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= OwnPipe;
            cnt_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            p_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            p_rdata_q <= p_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // Combinational so a fresh request stalls in its very first cycle.
    assign bus.p_stall = bus.p_req && !(state_q == StResp && owner_q == OwnPipe);
    assign bus.l_ack   = (state_q == StResp) && (owner_q == OwnLdr);
    assign bus.p_rdata = p_rdata_q;
    assign bus.l_rdata = l_rdata_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

endmodule
